imm_extend_pipe: RTL and testbench
==================================

// Module: imm_extend_pipe
// PURPOSE
//   Registered, handshaked immediate generator for the decode stage. Takes the
//   instruction bits [31:7], an immediate-type select and a sideband tag.
//   Returns the sign- or zero-extended XLEN-bit immediate one cycle later
//   through a valid/ready interface.
//   A 2-entry skid buffer lets a stalled execute stage back-pressure decode
//   without dropping data. Supports RV32/RV64 and adds U, CSR-uimm and shamt
//   forms.
// PARAMETERS
//   XLEN   32  result width; legal values 32 or 64
//   TAG_W  32  sideband width (PC / rd / ROB tag), carried unchanged with each entry
// PORTS
//   clk          in   1        clock, all state updates on rising edge
//   rst          in   1        asynchronous, active-high reset
//   flush        in   1        synchronous pipeline flush (branch/trap redirect)
//   in_valid     in   1        input entry present
//   in_ready     out  1        block can accept an entry this cycle
//   ImmSrc       in   3        immediate type select (encoding below)
//   Instr31_7    in   25       instruction bits [31:7]
//   in_tag       in   TAG_W    sideband in
//   out_valid    out  1        ImmExt/out_tag/out_illegal valid
//   out_ready    in   1        consumer accepts this cycle
//   ImmExt       out  XLEN     extended immediate
//   out_tag      out  TAG_W    sideband out
//   out_illegal  out  1        entry had ImmSrc=111
// BEHAVIOUR
//   Encoding. s = Instr[31], sign-extended to XLEN unless marked zero-extended:
//   - 000 I: s, [31:20]
//   - 001 S: s, [31:25], [11:7]
//   - 010 B: s, [7], [30:25], [11:8], 0
//   - 011 J: s, [19:12], [20], [30:21], 0
//   - 100 U: s, [31:12], 12'b0 (sign-extends above bit 31 when XLEN=64)
//   - 101 Z: zero-ext [19:15] (CSR uimm)
//   - 110 SH: zero-ext [25:20] if XLEN=64, else zero-ext [24:20]
//   - 111 ILLEGAL: ImmExt = 0, out_illegal = 1
//   Storage: output register OUT and skid register SKD, each with a valid bit.
//   - Accept when in_valid && in_ready. Pop when out_valid && out_ready.
//   - in_ready = !SKD.valid; it is a registered flag, not combinational from out_ready.
//   Occupancy states and transitions (EMPTY = neither valid, ONE = OUT only,
//   FULL = OUT + SKD). Next state is evaluated from accept and pop in the same cycle:
//   - EMPTY + accept -> ONE (latency exactly 1 cycle).
//   - ONE + accept + pop -> ONE; OUT is reloaded with the new entry, giving
//     1 entry/cycle throughput.
//   - ONE + accept, no pop -> FULL; the new entry goes to SKD.
//   - ONE + pop, no accept -> EMPTY.
//   - FULL + pop -> ONE; SKD moves to OUT and in_ready rises the next cycle.
//     No accept is possible while FULL.
//   Ordering: strictly FIFO; tag, immediate and illegal flag always travel together.
//   flush: next cycle both valids = 0 and in_ready = 1.
//   - flush has priority over a simultaneous accept (the entry is dropped) and
//     over a simultaneous pop.
//   rst (async, at any time including mid-stall):
//   - out_valid = 0, in_ready = 1 (SKD.valid = 0).
//   - ImmExt, out_tag and out_illegal = 0.
//   ImmExt/out_tag are held stable while out_valid && !out_ready.
//   Data registers update only on accept, pop or reset; no X propagation.
// TESTING
//   - Reset: assert rst mid-FULL -> out_valid=0, in_ready=1, ImmExt=0 immediately.
//   - I/S/U, XLEN=32, out_ready=1:
//     - 0xFFF00093 I -> ImmExt=0xFFFFFFFF
//     - 0xFE112E23 S -> 0xFFFFFFFC
//     - 0x123450B7 U -> 0x12345000
//     - each one cycle after accept, back-to-back.
//   - B/J/Z/SH/ILLEGAL:
//     - 0xFE000EE3 B -> 0xFFFFFFFC
//     - 0xFF9FF06F J -> 0xFFFFFFF8
//     - 0x0002D073 Z -> 0x00000005
//     - 0x01F09093 SH -> 0x1F
//     - ImmSrc=111 -> ImmExt=0 and out_illegal=1.
//   - XLEN=64: 0x800000B7 U -> 0xFFFFFFFF80000000; 0x03F09093 SH -> 0x3F.
//   - Back-pressure:
//     - send tags 1,2,3 with out_ready=0 -> tag 1 held on output, tag 2 in SKD,
//       in_ready=0, tag 3 not accepted.
//     - release out_ready -> tags emerge 1,2,3 in order, none lost or duplicated.
//   - Flush: FULL state plus simultaneous in_valid and flush -> next cycle
//     out_valid=0, in_ready=1, and the flushed entry never appears on the output.

Source files
------------

// File: rtl/imm_extend_pipe.sv
// Decode-stage immediate generator with a valid/ready output register and a
// one-entry skid register, so execute can stall without decode dropping data.
module imm_extend_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       ImmSrc,
    input  logic [24:0]      Instr31_7,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  ImmExt,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_illegal
);

    logic [31:7]      w_ins;
    logic [31:0]      w_imm32;
    logic             w_zext;
    logic             w_ill;
    logic [XLEN-1:0]  w_imm;
    logic             w_accept;
    logic             w_pop;

    logic             r_out_valid;
    logic [XLEN-1:0]  r_out_imm;
    logic [TAG_W-1:0] r_out_tag;
    logic             r_out_ill;
    logic             r_skd_valid;
    logic [XLEN-1:0]  r_skd_imm;
    logic [TAG_W-1:0] r_skd_tag;
    logic             r_skd_ill;

    assign w_ins = Instr31_7;

    // Every form is built as a 32-bit pattern first, then widened to XLEN
    // either by sign or by zero extension.
    always_comb begin
        w_imm32 = 32'd0;
        w_zext  = 1'b0;
        w_ill   = 1'b0;
        case (ImmSrc)
            3'b000: w_imm32 = {{20{w_ins[31]}}, w_ins[31:20]};
            3'b001: w_imm32 = {{20{w_ins[31]}}, w_ins[31:25], w_ins[11:7]};
            3'b010: w_imm32 = {{19{w_ins[31]}}, w_ins[31], w_ins[7], w_ins[30:25],
                               w_ins[11:8], 1'b0};
            3'b011: w_imm32 = {{11{w_ins[31]}}, w_ins[31], w_ins[19:12], w_ins[20],
                               w_ins[30:21], 1'b0};
            3'b100: w_imm32 = {w_ins[31:12], 12'd0};
            3'b101: begin
                w_imm32 = {27'd0, w_ins[19:15]};
                w_zext  = 1'b1;
            end
            3'b110: begin
                w_imm32 = (XLEN == 64) ? {26'd0, w_ins[25:20]} : {27'd0, w_ins[24:20]};
                w_zext  = 1'b1;
            end
            default: begin
                w_imm32 = 32'd0;
                w_zext  = 1'b1;
                w_ill   = 1'b1;
            end
        endcase
    end

    assign w_imm    = w_zext ? XLEN'(w_imm32) : XLEN'($signed(w_imm32));
    assign in_ready = ~r_skd_valid;
    assign w_accept = in_valid & ~r_skd_valid;
    assign w_pop    = r_out_valid & out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_imm   <= '0;
            r_out_tag   <= '0;
            r_out_ill   <= 1'b0;
            r_skd_valid <= 1'b0;
            r_skd_imm   <= '0;
            r_skd_tag   <= '0;
            r_skd_ill   <= 1'b0;
        end else if (flush) begin
            r_out_valid <= 1'b0;
            r_skd_valid <= 1'b0;
        end else if (!r_out_valid) begin
            if (w_accept) begin
                r_out_valid <= 1'b1;
                r_out_imm   <= w_imm;
                r_out_tag   <= in_tag;
                r_out_ill   <= w_ill;
            end
        end else if (!r_skd_valid) begin
            if (w_accept && w_pop) begin
                r_out_imm <= w_imm;
                r_out_tag <= in_tag;
                r_out_ill <= w_ill;
            end else if (w_accept) begin
                r_skd_valid <= 1'b1;
                r_skd_imm   <= w_imm;
                r_skd_tag   <= in_tag;
                r_skd_ill   <= w_ill;
            end else if (w_pop) begin
                r_out_valid <= 1'b0;
            end
        end else if (w_pop) begin
            // Skid drains into the output; input reopens next cycle.
            r_out_imm   <= r_skd_imm;
            r_out_tag   <= r_skd_tag;
            r_out_ill   <= r_skd_ill;
            r_skd_valid <= 1'b0;
        end
    end

    assign out_valid   = r_out_valid;
    assign ImmExt      = r_out_imm;
    assign out_tag     = r_out_tag;
    assign out_illegal = r_out_ill;

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Bench for imm_extend_pipe: fixed vectors at XLEN 32 and 64, back-pressure,
// flush, async reset and a randomized run against a queue-based FIFO model.
module tb_imm_extend_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [2:0]  imm_src = 3'd0;
    logic [31:0] instr = 32'd0;
    logic [31:0] in_tag = 32'd0;

    logic        in_ready32, out_valid32, ill32;
    logic [31:0] imm32, tag32;
    logic        in_ready64, out_valid64, ill64;
    logic [63:0] imm64;
    logic [31:0] tag64;

    int errors = 0;
    int checks = 0;

    imm_extend_pipe #(.XLEN(32), .TAG_W(32)) dut32 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready32),
        .ImmSrc(imm_src), .Instr31_7(instr[31:7]), .in_tag(in_tag),
        .out_valid(out_valid32), .out_ready(out_ready), .ImmExt(imm32),
        .out_tag(tag32), .out_illegal(ill32));

    imm_extend_pipe #(.XLEN(64), .TAG_W(32)) dut64 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready64),
        .ImmSrc(imm_src), .Instr31_7(instr[31:7]), .in_tag(in_tag),
        .out_valid(out_valid64), .out_ready(out_ready), .ImmExt(imm64),
        .out_tag(tag64), .out_illegal(ill64));

    always #5 clk = ~clk;

    // Immediate value from field weights, as a signed integer.
    function automatic logic [63:0] ref_imm(logic [31:0] ins, logic [2:0] src, int xlen);
        longint v;
        case (src)
            3'd0: v = longint'(ins[31:20]) - (ins[31] ? 64'sd4096 : 64'sd0);
            3'd1: v = longint'(ins[31:25]) * 32 + longint'(ins[11:7])
                      - (ins[31] ? 64'sd4096 : 64'sd0);
            3'd2: v = longint'(ins[7]) * 2048 + longint'(ins[30:25]) * 32
                      + longint'(ins[11:8]) * 2 - (ins[31] ? 64'sd4096 : 64'sd0);
            3'd3: v = longint'(ins[19:12]) * 4096 + longint'(ins[20]) * 2048
                      + longint'(ins[30:21]) * 2 - (ins[31] ? 64'sd1048576 : 64'sd0);
            3'd4: v = longint'(ins[31:12]) * 4096 - (ins[31] ? 64'sd4294967296 : 64'sd0);
            3'd5: v = longint'(ins[19:15]);
            3'd6: v = (xlen == 64) ? longint'(ins[25:20]) : longint'(ins[24:20]);
            default: v = 0;
        endcase
        if (xlen == 32) return {32'd0, v[31:0]};
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        checks++;
        if (out_valid32 !== 1'b0 || in_ready32 !== 1'b1 || imm32 !== 32'd0 ||
            tag32 !== 32'd0 || ill32 !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: ov=%b ir=%b imm=%h tag=%h ill=%b, want 0 1 0 0 0",
                     out_valid32, in_ready32, imm32, tag32, ill32);
        end
        @(negedge clk);
        #2 rst = 1'b0;
        step();
        in_valid = 1'b1; out_ready = 1'b0; imm_src = 3'd0; instr = 32'hFFF00093; in_tag = 32'hA;
        step();
        in_tag = 32'hB;
        step();
        in_valid = 1'b0;
        checks++;
        if (out_valid32 !== 1'b1 || in_ready32 !== 1'b0) begin
            errors++;
            $display("FAIL reset_fill: ov=%b ir=%b, want 1 0", out_valid32, in_ready32);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (out_valid32 !== 1'b0 || in_ready32 !== 1'b1 || imm32 !== 32'd0 ||
            out_valid64 !== 1'b0 || in_ready64 !== 1'b1 || imm64 !== 64'd0 || tag32 !== 32'd0) begin
            errors++;
            $display("FAIL reset_async: ov=%b ir=%b imm=%h imm64=%h tag=%h, want 0 1 0 0 0",
                     out_valid32, in_ready32, imm32, imm64, tag32);
        end
        #3 rst = 1'b0;
        step();
        checks++;
        if (out_valid32 !== 1'b0 || in_ready32 !== 1'b1) begin
            errors++;
            $display("FAIL reset_after: ov=%b ir=%b, want 0 1", out_valid32, in_ready32);
        end
        $display("reset: done");
    endtask

    task automatic test_vectors();
        logic [31:0] v_ins [10];
        logic [2:0]  v_src [10];
        logic [31:0] v_e32 [10];
        logic [63:0] v_e64 [10];
        v_ins[0] = 32'hFFF00093; v_src[0] = 3'd0; v_e32[0] = 32'hFFFFFFFF; v_e64[0] = 64'hFFFFFFFFFFFFFFFF;
        v_ins[1] = 32'hFE112E23; v_src[1] = 3'd1; v_e32[1] = 32'hFFFFFFFC; v_e64[1] = 64'hFFFFFFFFFFFFFFFC;
        v_ins[2] = 32'h123450B7; v_src[2] = 3'd4; v_e32[2] = 32'h12345000; v_e64[2] = 64'h0000000012345000;
        v_ins[3] = 32'hFE000EE3; v_src[3] = 3'd2; v_e32[3] = 32'hFFFFFFFC; v_e64[3] = 64'hFFFFFFFFFFFFFFFC;
        v_ins[4] = 32'hFF9FF06F; v_src[4] = 3'd3; v_e32[4] = 32'hFFFFFFF8; v_e64[4] = 64'hFFFFFFFFFFFFFFF8;
        v_ins[5] = 32'h0002D073; v_src[5] = 3'd5; v_e32[5] = 32'h00000005; v_e64[5] = 64'h5;
        v_ins[6] = 32'h01F09093; v_src[6] = 3'd6; v_e32[6] = 32'h0000001F; v_e64[6] = 64'h1F;
        v_ins[7] = 32'hFFFFFFFF; v_src[7] = 3'd7; v_e32[7] = 32'h00000000; v_e64[7] = 64'h0;
        v_ins[8] = 32'h800000B7; v_src[8] = 3'd4; v_e32[8] = 32'h80000000; v_e64[8] = 64'hFFFFFFFF80000000;
        v_ins[9] = 32'h03F09093; v_src[9] = 3'd6; v_e32[9] = 32'h0000001F; v_e64[9] = 64'h3F;
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1; instr = v_ins[i]; imm_src = v_src[i]; in_tag = 32'd100 + i;
            step();
            checks++;
            if (out_valid32 !== 1'b1 || imm32 !== v_e32[i] || tag32 !== 32'd100 + i ||
                ill32 !== (v_src[i] == 3'd7) || in_ready32 !== 1'b1) begin
                errors++;
                $display("FAIL vec32_%0d: ov=%b imm=%h tag=%0d ill=%b ir=%b, want 1 %h %0d %b 1",
                         i, out_valid32, imm32, tag32, ill32, in_ready32, v_e32[i], 100 + i, v_src[i] == 3'd7);
            end
            checks++;
            if (out_valid64 !== 1'b1 || imm64 !== v_e64[i] || tag64 !== 32'd100 + i ||
                ill64 !== (v_src[i] == 3'd7)) begin
                errors++;
                $display("FAIL vec64_%0d: ov=%b imm=%h tag=%0d ill=%b, want 1 %h %0d %b",
                         i, out_valid64, imm64, tag64, ill64, v_e64[i], 100 + i, v_src[i] == 3'd7);
            end
            $display("vec %0d: src=%0d ins=%h imm32=%h imm64=%h", i, v_src[i], v_ins[i], imm32, imm64);
        end
        in_valid = 1'b0;
        step();
        checks++;
        if (out_valid32 !== 1'b0 || out_valid64 !== 1'b0) begin
            errors++;
            $display("FAIL vec_drain: ov32=%b ov64=%b, want 0 0", out_valid32, out_valid64);
        end
    endtask

    task automatic test_back_pressure();
        int got [$];
        out_ready = 1'b0; imm_src = 3'd0; instr = 32'h00100093;
        in_valid = 1'b1; in_tag = 32'd1;
        step();
        in_tag = 32'd2;
        step();
        in_tag = 32'd3;
        for (int c = 0; c < 3; c++) begin
            step();
            checks++;
            if (out_valid32 !== 1'b1 || tag32 !== 32'd1 || in_ready32 !== 1'b0 || in_ready64 !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold_%0d: ov=%b tag=%0d ir=%b ir64=%b, want 1 1 0 0",
                         c, out_valid32, tag32, in_ready32, in_ready64);
            end
        end
        out_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            logic acc;
            acc = in_valid && in_ready32;
            if (out_valid32 && out_ready) got.push_back(int'(tag32));
            step();
            if (acc) in_valid = 1'b0;
        end
        checks++;
        if (got.size() != 3 || got[0] != 1 || got[1] != 2 || got[2] != 3) begin
            errors++;
            $display("FAIL bp_order: got %0d tags (%p), want 1,2,3", got.size(), got);
        end
        $display("back_pressure: tags out %p", got);
    endtask

    task automatic test_flush();
        out_ready = 1'b0; imm_src = 3'd4; instr = 32'h12345037;
        in_valid = 1'b1; in_tag = 32'h11;
        step();
        in_tag = 32'h22;
        step();
        in_tag = 32'h55; flush = 1'b1; out_ready = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        checks++;
        if (out_valid32 !== 1'b0 || in_ready32 !== 1'b1 || out_valid64 !== 1'b0) begin
            errors++;
            $display("FAIL flush_full: ov=%b ir=%b ov64=%b, want 0 1 0", out_valid32, in_ready32, out_valid64);
        end
        in_valid = 1'b1; in_tag = 32'h66;
        step();
        in_tag = 32'h77; flush = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            checks++;
            if (out_valid32 !== 1'b0 || in_ready32 !== 1'b1) begin
                errors++;
                $display("FAIL flush_drop_%0d: ov=%b ir=%b tag=%h, want 0 1", c, out_valid32, in_ready32, tag32);
            end
            step();
        end
        $display("flush: done");
    endtask

    task automatic test_random();
        logic [31:0] q_ins [$];
        logic [2:0]  q_src [$];
        logic [31:0] q_tag [$];
        logic        acc, pop;
        for (int c = 0; c < 400; c++) begin
            in_valid  = ($urandom_range(0, 9) < 6);
            out_ready = ($urandom_range(0, 9) < 5);
            flush     = ($urandom_range(0, 99) < 3);
            instr     = $urandom;
            imm_src   = 3'($urandom_range(0, 7));
            in_tag    = $urandom;
            checks++;
            if (out_valid32 !== (q_ins.size() > 0) || in_ready32 !== (q_ins.size() < 2) ||
                out_valid64 !== (q_ins.size() > 0) || in_ready64 !== (q_ins.size() < 2)) begin
                errors++;
                $display("FAIL rnd_hs_%0d: ov=%b ir=%b ov64=%b ir64=%b, occupancy %0d",
                         c, out_valid32, in_ready32, out_valid64, in_ready64, q_ins.size());
            end else if (q_ins.size() > 0) begin
                logic [63:0] e32, e64;
                e32 = ref_imm(q_ins[0], q_src[0], 32);
                e64 = ref_imm(q_ins[0], q_src[0], 64);
                checks++;
                if (imm32 !== e32[31:0] || imm64 !== e64 || tag32 !== q_tag[0] || tag64 !== q_tag[0] ||
                    ill32 !== (q_src[0] == 3'd7) || ill64 !== (q_src[0] == 3'd7)) begin
                    errors++;
                    $display("FAIL rnd_data_%0d: imm32=%h imm64=%h tag=%h ill=%b, want %h %h %h %b",
                             c, imm32, imm64, tag32, ill32, e32[31:0], e64, q_tag[0], q_src[0] == 3'd7);
                end
            end
            acc = in_valid && (q_ins.size() < 2);
            pop = out_ready && (q_ins.size() > 0);
            step();
            if (flush) begin
                q_ins.delete(); q_src.delete(); q_tag.delete();
            end else begin
                if (pop) begin
                    void'(q_ins.pop_front()); void'(q_src.pop_front()); void'(q_tag.pop_front());
                end
                if (acc) begin
                    q_ins.push_back(instr); q_src.push_back(imm_src); q_tag.push_back(in_tag);
                end
            end
        end
        flush = 1'b0; in_valid = 1'b0;
        $display("random: 400 cycles done");
    endtask

    initial begin
        #12;
        test_reset();
        test_vectors();
        test_back_pressure();
        test_flush();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
